// File: rtl/adc_cfg_seq.sv
// adc_cfg_seq: Wishbone master that streams a table of SPI command words
// to each enabled ADC through the shared SPI master slave.
module adc_cfg_seq #(
    parameter int NWORDS    = 8,
    parameter int XFER_WAIT = 1600,
    parameter int ACK_TMO   = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        start,
    input  logic [3:0]  adc_mask,
    output logic [7:0]  tbl_adr,
    input  logic [15:0] tbl_dat,
    output logic        wb_adr_o,
    output logic [15:0] wb_dat_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [3:0] {IDLE, SKIP, SETCS, FETCH, WRDAT, WAIT, DESEL, DONE, ERR} state_t;
    state_t      state, state_d;
    logic [3:0]  mask;
    logic [2:0]  adc;
    logic [7:0]  word;
    logic [15:0] xcnt;
    logic [7:0]  tmo;
    logic [15:0] data;
    logic        ph;
    logic        acc, can_start, fail, ack, xfer_end, last;
    logic [3:0]  pending;
    logic [2:0]  first;
    assign acc       = state inside {SETCS, WRDAT, DESEL};
    assign can_start = start && (state inside {IDLE, DONE, ERR});
    // error beats ack; timeout only when no ack arrives in the same cycle
    assign fail      = acc && (wb_err_i || (!wb_ack_i && 32'(tmo) >= ACK_TMO));
    assign ack       = acc && wb_ack_i && !wb_err_i;
    // a 3-bit index lets adc step past ADC 3, leaving nothing pending
    assign pending   = mask & (4'hF << adc);
    assign first     = pending[0] ? 3'd0 : pending[1] ? 3'd1 : pending[2] ? 3'd2 : 3'd3;
    assign xfer_end  = 32'(xcnt) + 32'd1 >= XFER_WAIT;
    assign last      = 32'(word) == NWORDS - 1;
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) state <= IDLE;
        else           state <= state_d;
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = can_start ? SKIP : IDLE;
            SKIP:    state_d = pending == 4'd0 ? DONE : SETCS;
            SETCS:   state_d = fail ? ERR : ack ? FETCH : SETCS;
            FETCH:   state_d = ph ? WRDAT : FETCH;
            WRDAT:   state_d = fail ? ERR : ack ? WAIT : WRDAT;
            WAIT:    state_d = !xfer_end ? WAIT : last ? DESEL : FETCH;
            DESEL:   state_d = fail ? ERR : ack ? SKIP : DESEL;
            DONE:    state_d = can_start ? SKIP : IDLE;
            ERR:     state_d = can_start ? SKIP : ERR;
            default: state_d = IDLE;
        endcase
    end
    // FETCH spends one cycle letting the sync ROM settle, then captures the word
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            mask <= '0;
            adc  <= '0;
            word <= '0;
            xcnt <= '0;
            tmo  <= '0;
            data <= '0;
            ph   <= 1'b0;
        end else begin
            tmo  <= acc ? tmo + 8'd1 : 8'd0;
            xcnt <= state == WAIT ? xcnt + 16'd1 : 16'd0;
            ph   <= state == FETCH && !ph;
            if (state == FETCH && ph) data <= tbl_dat;
            if (can_start) begin
                mask <= adc_mask;
                adc  <= '0;
                word <= '0;
            end
            if (state == SKIP) begin
                adc  <= first;
                word <= '0;
            end
            if (state == WAIT && xfer_end && !last) word <= word + 8'd1;
            if (state == DESEL && ack) adc <= adc + 3'd1;
        end
    end
    assign wb_cyc_o = acc;
    assign wb_stb_o = acc;
    assign wb_we_o  = acc;
    assign wb_adr_o = state == SETCS || state == DESEL;
    assign wb_dat_o = state == SETCS ? 16'd1 << adc[1:0] : state == WRDAT ? data : 16'd0;
    assign tbl_adr  = word;
    assign busy     = !(state inside {IDLE, DONE, ERR});
    assign done     = state == DONE;
    assign err      = state == ERR;
endmodule

// File: tb/tb_adc_cfg_seq.sv
// tb_adc_cfg_seq: directed and randomized checks of adc_cfg_seq against a
// table-driven model of the expected Wishbone write sequence.
module tb_adc_cfg_seq;
    localparam int NW  = 2;
    localparam int XW  = 10;
    localparam int TMO = 255;
    logic        wb_clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  adc_mask = 4'd0;
    logic [7:0]  tbl_adr;
    logic [15:0] tbl_dat;
    logic        wb_adr_o;
    logic [15:0] wb_dat_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i = 1'b0;
    logic        busy, done, err;
    int          tests = 0;
    int          fails = 0;
    int          cyc_n = 0;
    logic        no_ack = 1'b0;
    logic [1:0]  lat;
    logic [15:0] rom [256];
    logic [17:0] wr_q [$];
    int          dack_t [$];

    adc_cfg_seq #(.NWORDS(NW), .XFER_WAIT(XW), .ACK_TMO(TMO)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .start(start), .adc_mask(adc_mask),
        .tbl_adr(tbl_adr), .tbl_dat(tbl_dat), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .busy(busy), .done(done), .err(err)
    );

    always #5 wb_clk = ~wb_clk;
    always @(posedge wb_clk) tbl_dat <= rom[tbl_adr];

    // slave: acks after 0..3 cycles and logs {we, adr, dat} of each accepted write
    always @(posedge wb_clk) begin
        cyc_n <= cyc_n + 1;
        if (wb_cyc_o && wb_stb_o && !wb_ack_i && !no_ack) begin
            if (lat == 2'd0) begin
                wb_ack_i <= 1'b1;
                wr_q.push_back({wb_we_o, wb_adr_o, wb_dat_o});
                if (!wb_adr_o) dack_t.push_back(cyc_n);
            end else lat <= lat - 2'd1;
        end else begin
            wb_ack_i <= 1'b0;
            lat <= 2'($urandom_range(0, 3));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic outs_zero(input string tag);
        check(tag, {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, tbl_adr, busy, done, err}, 32'd0);
    endtask

    task automatic run(input logic [3:0] m, input int restart_at);
        logic [17:0] exp_q [$];
        int n;
        exp_q = {};
        for (int k = 0; k < 4; k++) begin
            if (m[k]) begin
                exp_q.push_back({2'b11, 16'(1 << k)});
                for (int w = 0; w < NW; w++) exp_q.push_back({2'b10, rom[w]});
                exp_q.push_back({2'b11, 16'h0000});
            end
        end
        wr_q = {};
        dack_t = {};
        @(negedge wb_clk);
        start = 1'b1;
        adc_mask = m;
        @(negedge wb_clk);
        start = 1'b0;
        adc_mask = 4'($urandom);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && !err && n < 4000) begin
            if (n == restart_at) begin
                start = 1'b1;
                adc_mask = ~m;
            end else start = 1'b0;
            @(negedge wb_clk);
            n++;
        end
        start = 1'b0;
        check("run_done", {31'd0, done}, 32'd1);
        check("run_busy_at_done", {31'd0, busy}, 32'd0);
        check("run_err", {31'd0, err}, 32'd0);
        @(negedge wb_clk);
        check("done_pulse_len", {31'd0, done}, 32'd0);
        check("n_writes", wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("write_%0d", i), {14'd0, i < wr_q.size() ? wr_q[i] : 18'h3FFFF}, {14'd0, exp_q[i]});
        if (dack_t.size() >= 2) check("xfer_gap", {31'd0, dack_t[1] - dack_t[0] > XW}, 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        repeat (3) @(negedge wb_clk);
        outs_zero("reset_outputs");
        wb_rst_n = 1'b1;
        @(negedge wb_clk);
        outs_zero("idle_after_reset");

        rom[0] = 16'h1234;
        rom[1] = 16'hABCD;
        run(4'b0001, -1);

        rom[0] = 16'($urandom);
        rom[1] = 16'($urandom);
        run(4'b1010, -1);

        // empty mask: one busy cycle, then a single done pulse, no bus traffic
        wr_q = {};
        @(negedge wb_clk);
        start = 1'b1;
        adc_mask = 4'd0;
        @(negedge wb_clk);
        start = 1'b0;
        check("m0_busy", {30'd0, busy, done}, 32'd2);
        @(negedge wb_clk);
        check("m0_done", {30'd0, busy, done}, 32'd1);
        @(negedge wb_clk);
        check("m0_idle", {30'd0, busy, done}, 32'd0);
        check("m0_no_writes", wr_q.size(), 32'd0);

        for (int r = 0; r < 4; r++) begin
            rom[0] = 16'($urandom);
            rom[1] = 16'($urandom);
            run(4'($urandom_range(1, 15)), -1);
        end

        // start pulse while busy must not disturb the running sequence
        run(4'b0011, 20);

        // slave never acks: cyc held ACK_TMO+1 cycles, then ERR
        no_ack = 1'b1;
        @(negedge wb_clk);
        start = 1'b1;
        adc_mask = 4'b0100;
        @(negedge wb_clk);
        start = 1'b0;
        n = 0;
        while (!wb_cyc_o && n < 50) begin
            @(negedge wb_clk);
            n++;
        end
        n = 0;
        while (wb_cyc_o && n < 400) begin
            @(negedge wb_clk);
            n++;
        end
        check("tmo_cyc_len", n, TMO + 1);
        check("tmo_err", {30'd0, err, busy}, 32'd2);
        repeat (3) @(negedge wb_clk);
        check("tmo_err_sticky", {29'd0, err, busy, wb_cyc_o}, 32'd4);
        no_ack = 1'b0;
        start = 1'b1;
        adc_mask = 4'd0;
        @(negedge wb_clk);
        start = 1'b0;
        check("err_cleared", {30'd0, err, busy}, 32'd1);
        @(negedge wb_clk);
        check("err_clear_done", {31'd0, done}, 32'd1);

        // reset in the middle of a data write
        @(negedge wb_clk);
        start = 1'b1;
        adc_mask = 4'b0001;
        @(negedge wb_clk);
        start = 1'b0;
        n = 0;
        while (!(wb_cyc_o && !wb_adr_o) && n < 200) begin
            @(negedge wb_clk);
            n++;
        end
        check("wrdat_reached", {31'd0, wb_cyc_o && !wb_adr_o}, 32'd1);
        wb_rst_n = 1'b0;
        #1;
        check("rst_drop", {29'd0, wb_cyc_o, wb_stb_o, busy}, 32'd0);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk);
            outs_zero($sformatf("post_rst_%0d", i));
        end
        run(4'b0001, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adc_cfg_seq.md
Name: adc_cfg_seq

Overview:
- Wishbone master that configures the four on-board ADCs after power-up or on command.
- Walks a table of 16-bit SPI command words and, for each enabled ADC, pushes every word through the ADC SPI master (xspi_master WB slave).
- Handles chip-select, inter-word spacing and ack timeout, so the board bring-up no longer needs one SPI frame from the master Xilinx per ADC register write.
- Sits in the wb_clk domain and shares the adc_spi slave through the WB intercon as an additional master.

Parameters:
- NWORDS, 8: number of table entries sent to each ADC (1..256).
- XFER_WAIT, 1600: wb_clk cycles to wait after a data-write ack before the next access; covers 16 bits at CLK_DIV 49.
- ACK_TMO, 255: maximum wb_clk cycles to wait for wb_ack_i on any access.

Ports:
- wb_clk, in, 1: Wishbone clock, the single clock of the block.
- wb_rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle pulse that begins a sequence.
- adc_mask, in, 4: bit k=1 enables ADC k; sampled on start.
- tbl_adr, out, 8: table word address; width fixed at 8 bits, upper bits zero when NWORDS<256.
- tbl_dat, in, 16: table word, valid 1 cycle after tbl_adr changes (sync ROM).
- wb_adr_o, out, 1: register select; 0 = data (write starts transfer), 1 = CS register. Top maps it to adr[2].
- wb_dat_o, out, 16: write data.
- wb_we_o, out, 1: always 1 while cyc (write-only master).
- wb_cyc_o, out, 1: bus cycle.
- wb_stb_o, out, 1: strobe.
- wb_ack_i, in, 1: slave ack.
- wb_err_i, in, 1: slave error.
- busy, out, 1: high from the cycle after start until DONE/ERR.
- done, out, 1: 1-cycle pulse on successful completion.
- err, out, 1: sticky error; cleared by the next accepted start.

Behaviour:
- Reset (async, wb_rst_n=0): state IDLE. All outputs 0: cyc, stb, we, adr, dat, tbl_adr, busy, done, err. Internal counters and the latched mask are cleared.
- start accepted only in IDLE, DONE or ERR; ignored while busy.
  - On accept: latch adc_mask, clear err, set adc index to 0 and word index to 0.
  - If the latched mask is 0: go directly to DONE (busy high 1 cycle, then done pulse).
- States:
  - IDLE: wait for start.
  - SKIP: advance the adc index past disabled ADCs; after ADC 3 go to DONE.
  - SETCS: WB write adr=1, dat=16'h0001<<adc.
  - FETCH: drive tbl_adr=word index; 1 wait cycle for the ROM.
  - WRDAT: WB write adr=0, dat=tbl_dat as registered in FETCH.
  - WAIT: count XFER_WAIT cycles, then word+1 and FETCH. After the last word (word index = NWORDS-1) go to DESEL.
  - DESEL: WB write adr=1, dat=16'h0000; then adc+1 and SKIP.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
  - ERR: busy=0, err=1; hold until start.
- WB access rules:
  - cyc and stb rise together in the state's first cycle and drop in the cycle after ack is sampled; we=1 throughout.
  - adr and dat are stable for the whole access.
  - Classic single write only; no bursts, so cti/bte are not generated.
- Ack timeout: a counter starts with stb. If ACK_TMO cycles pass without ack, or wb_err_i=1, drop cyc/stb the next cycle and go to ERR. No deselect is attempted.
- ack and err in the same cycle: err wins.
- Ordering for each enabled ADC: SETCS, then NWORDS x (FETCH, WRDAT, WAIT), then DESEL. ADCs are processed in ascending index order.
- Counter widths: word index 8 bits, XFER counter 16 bits, timeout counter 8 bits. No wrap is possible within legal parameter ranges.
- Reset mid-access drops cyc/stb immediately (async). The slave-side transfer is abandoned.

Test Plan:
1. Reset, then start with adc_mask=4'b0001, NWORDS=2, XFER_WAIT=10, table {16'h1234, 16'hABCD}. Required WB writes in order: (1,16'h0001), (0,16'h1234), (0,16'hABCD), (1,16'h0000). At least 10 idle cycles between the two data acks. Then done pulse 1 cycle, busy 0.
2. adc_mask=4'b1010 -> CS writes 16'h0002, 16'h0000, 16'h0008, 16'h0000 in that order; ADCs 0 and 2 are never selected.
3. adc_mask=0 -> busy for exactly 1 cycle, done the next cycle, no WB activity.
4. Slave never acks, ACK_TMO=255 -> cyc drops 256 cycles after stb rose, err=1, busy=0. A new start clears err.
5. Pulse start again while busy -> ignored: access sequence and word count unchanged.
6. Assert wb_rst_n=0 during WRDAT -> cyc/stb/busy drop at once. After release, outputs stay 0 until the next start.
